// File: rtl/csr_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_access_ctrl_if
// Description : Requester, response and CSR-file signals of csr_access_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface csr_access_ctrl_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [23:0] req_addr;
    logic [3:0]  req_op;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_ready;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_we;
    logic [31:0] csr_rdata;
    logic        csr_valid;

    // Controller view
    modport slave (
        input  req_valid, req_addr, req_op, req_wdata, rsp_ready, csr_rdata, csr_valid,
        output req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, csr_addr, csr_wdata, csr_we
    );

    // Requesters plus CSR file view
    modport master (
        output req_valid, req_addr, req_op, req_wdata, rsp_ready, csr_rdata, csr_valid,
        input  req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, csr_addr, csr_wdata, csr_we
    );
endinterface
`default_nettype wire

// File: rtl/csr_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : csr_access_ctrl
// Description : Two-port arbitrated read-modify-write sequencer for Zicsr ops.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_access_ctrl #(
    parameter int ARB_MODE    = 0,
    parameter bit RO_CHECK_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    csr_access_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    state_t      state;
    state_t      state_nxt;

    logic        rr_ptr;
    logic [1:0]  grant;
    logic        grant_id;
    logic [11:0] sel_addr;
    logic [1:0]  sel_op;
    logic [31:0] sel_wdata;

    logic [1:0]  lat_op;
    logic [31:0] lat_wdata;
    logic [11:0] csr_addr_q;
    logic [31:0] csr_wdata_q;
    logic        write_q;
    logic        rsp_id_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic        ro_addr;
    logic        do_write;
    logic        access_err;
    logic [31:0] new_val;

    // Grants are withheld during reset so req_ready reads as zero.
    always_comb begin
        grant    = 2'b00;
        grant_id = 1'b0;
        if (state == S_IDLE && !rst) begin
            case (bus.req_valid)
                2'b01: begin
                    grant    = 2'b01;
                    grant_id = 1'b0;
                end
                2'b10: begin
                    grant    = 2'b10;
                    grant_id = 1'b1;
                end
                2'b11: begin
                    grant_id = (ARB_MODE == 1) ? 1'b0 : rr_ptr;
                    grant    = grant_id ? 2'b10 : 2'b01;
                end
                default: begin
                    grant    = 2'b00;
                    grant_id = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        sel_addr  = grant_id ? bus.req_addr[23:12]  : bus.req_addr[11:0];
        sel_op    = grant_id ? bus.req_op[3:2]      : bus.req_op[1:0];
        sel_wdata = grant_id ? bus.req_wdata[63:32] : bus.req_wdata[31:0];
    end

    // Read-modify-write evaluation against the live CSR file read in READ.
    always_comb begin
        ro_addr    = (csr_addr_q[11:10] == 2'b11);
        do_write   = (lat_op == OP_RW) ||
                     (((lat_op == OP_RS) || (lat_op == OP_RC)) && (lat_wdata != 32'd0));
        access_err = !bus.csr_valid || (RO_CHECK_EN && do_write && ro_addr);
        case (lat_op)
            OP_RW:   new_val = lat_wdata;
            OP_RS:   new_val = bus.csr_rdata | lat_wdata;
            OP_RC:   new_val = bus.csr_rdata & ~lat_wdata;
            OP_READ: new_val = bus.csr_rdata;
            default: new_val = bus.csr_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = grant;
        bus.rsp_valid = 1'b0;
        bus.csr_we    = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant != 2'b00) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                state_nxt = S_WRITE;
            end
            S_WRITE: begin
                bus.csr_we = write_q;
                state_nxt  = S_RESP;
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr      <= 1'b0;
            lat_op      <= OP_READ;
            lat_wdata   <= 32'd0;
            csr_addr_q  <= 12'd0;
            csr_wdata_q <= 32'd0;
            write_q     <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant != 2'b00) begin
                        rr_ptr     <= ~grant_id;
                        lat_op     <= sel_op;
                        lat_wdata  <= sel_wdata;
                        csr_addr_q <= sel_addr;
                        rsp_id_q   <= grant_id;
                    end
                end
                S_READ: begin
                    csr_wdata_q <= new_val;
                    // Read-only writes are dropped even when not flagged as errors.
                    write_q     <= do_write && !access_err && !ro_addr;
                    rsp_err_q   <= access_err;
                    rsp_rdata_q <= access_err ? 32'd0 : bus.csr_rdata;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.csr_addr  = csr_addr_q;
    assign bus.csr_wdata = csr_wdata_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_access_ctrl
// Description : Directed self-checking bench for csr_access_ctrl (both ARB modes).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_access_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   passed;
    int   we_cnt0;

    csr_access_ctrl_if bus0 ();
    csr_access_ctrl_if bus1 ();

    csr_access_ctrl #(.ARB_MODE(0), .RO_CHECK_EN(1'b1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    csr_access_ctrl #(.ARB_MODE(1), .RO_CHECK_EN(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus0.csr_we === 1'b1) we_cnt0 = we_cnt0 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Starts at a negedge with the DUT idle; ends at a negedge back in IDLE.
    task automatic txn(input logic port, input logic [11:0] addr, input logic [1:0] op,
                       input logic [31:0] wdata, input logic [31:0] old, input logic valid,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input logic exp_we, input logic [31:0] exp_wdata);
        int we_start;
        we_start         = we_cnt0;
        bus0.req_valid   = port ? 2'b10 : 2'b01;
        bus0.req_addr    = port ? {addr, 12'h000} : {12'h000, addr};
        bus0.req_op      = port ? {op, 2'b00} : {2'b00, op};
        bus0.req_wdata   = port ? {wdata, 32'h0} : {32'h0, wdata};
        bus0.csr_rdata   = old;
        bus0.csr_valid   = valid;
        #1;
        check("grant", {30'd0, bus0.req_ready}, port ? 32'd2 : 32'd1);
        @(negedge clk);
        bus0.req_valid = 2'b00;
        check("read_addr", {20'd0, bus0.csr_addr}, {20'd0, addr});
        check("read_ready", {30'd0, bus0.req_ready}, 32'd0);
        @(negedge clk);
        check("write_we", {31'd0, bus0.csr_we}, {31'd0, exp_we});
        check("write_addr", {20'd0, bus0.csr_addr}, {20'd0, addr});
        if (exp_we) check("write_data", bus0.csr_wdata, exp_wdata);
        @(negedge clk);
        check("rsp_valid", {31'd0, bus0.rsp_valid}, 32'd1);
        check("rsp_id", {31'd0, bus0.rsp_id}, {31'd0, port});
        check("rsp_rdata", bus0.rsp_rdata, exp_rdata);
        check("rsp_err", {31'd0, bus0.rsp_err}, {31'd0, exp_err});
        check("we_pulses", we_cnt0 - we_start, exp_we ? 32'd1 : 32'd0);
        @(negedge clk);
        check("rsp_done", {31'd0, bus0.rsp_valid}, 32'd0);
    endtask

    logic [1:0] exp_rr  [3];
    logic [1:0] exp_fix [3];
    int         we_snap;
    int         rsp_seen;

    initial begin
        total = 0; passed = 0; we_cnt0 = 0;
        exp_rr  = '{2'b01, 2'b10, 2'b01};
        exp_fix = '{2'b01, 2'b01, 2'b01};
        rst = 1'b1;
        bus0.req_valid = 2'b11; bus0.req_addr = '0; bus0.req_op = '0; bus0.req_wdata = '0;
        bus0.rsp_ready = 1'b1; bus0.csr_rdata = '0; bus0.csr_valid = 1'b1;
        bus1.req_valid = 2'b00; bus1.req_addr = '0; bus1.req_op = '0; bus1.req_wdata = '0;
        bus1.rsp_ready = 1'b1; bus1.csr_rdata = '0; bus1.csr_valid = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_ready", {30'd0, bus0.req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus0.rsp_valid}, 32'd0);
        check("rst_rsp_rdata", bus0.rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'd0, bus0.rsp_err}, 32'd0);
        check("rst_rsp_id", {31'd0, bus0.rsp_id}, 32'd0);
        check("rst_csr_addr", {20'd0, bus0.csr_addr}, 32'd0);
        check("rst_csr_wdata", bus0.csr_wdata, 32'd0);
        check("rst_csr_we", {31'd0, bus0.csr_we}, 32'd0);
        bus0.req_valid = 2'b00;
        rst = 1'b0;
        @(negedge clk);

        txn(1'b0, 12'hC00, 2'b00, 32'h0,         32'h0000_1234, 1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0);
        txn(1'b0, 12'hC02, 2'b10, 32'h1,         32'h0000_5678, 1'b1, 32'h0,         1'b1, 1'b0, 32'h0);
        txn(1'b0, 12'hC02, 2'b10, 32'h0,         32'h0000_5678, 1'b1, 32'h0000_5678, 1'b0, 1'b0, 32'h0);
        txn(1'b1, 12'h340, 2'b01, 32'h0000_00AA, 32'hFFFF_0000, 1'b1, 32'hFFFF_0000, 1'b0, 1'b1, 32'h0000_00AA);
        txn(1'b1, 12'h340, 2'b11, 32'hFFFF_0000, 32'hFFFF_0000, 1'b1, 32'hFFFF_0000, 1'b0, 1'b1, 32'h0000_0000);
        txn(1'b0, 12'h300, 2'b10, 32'h3,         32'h0000_0008, 1'b1, 32'h0000_0008, 1'b0, 1'b1, 32'h0000_000B);
        txn(1'b0, 12'h7FF, 2'b01, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0);
        txn(1'b0, 12'h000, 2'b00, 32'h0,         32'h0000_0042, 1'b1, 32'h0000_0042, 1'b0, 1'b0, 32'h0);

        // Response back-pressure: outputs must hold while a new request waits.
        bus0.rsp_ready = 1'b0;
        bus0.req_valid = 2'b01; bus0.req_addr = {12'h000, 12'h341}; bus0.req_op = 4'b0000;
        bus0.csr_rdata = 32'h0000_0099; bus0.csr_valid = 1'b1;
        @(negedge clk);
        bus0.req_valid = 2'b00;
        repeat (2) @(negedge clk);
        bus0.req_valid = 2'b10; bus0.csr_rdata = 32'hDEAD_0000;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_valid", {31'd0, bus0.rsp_valid}, 32'd1);
            check("stall_rdata", bus0.rsp_rdata, 32'h0000_0099);
            check("stall_id", {31'd0, bus0.rsp_id}, 32'd0);
            check("stall_err", {31'd0, bus0.rsp_err}, 32'd0);
            check("stall_ready", {30'd0, bus0.req_ready}, 32'd0);
            @(negedge clk);
        end
        bus0.req_valid = 2'b00;
        bus0.rsp_ready = 1'b1;
        @(negedge clk);
        check("stall_release", {31'd0, bus0.rsp_valid}, 32'd0);

        // Reset while the write strobe is active.
        bus0.req_valid = 2'b10; bus0.req_addr = {12'h340, 12'h000}; bus0.req_op = 4'b0100;
        bus0.req_wdata = {32'h0000_0055, 32'h0}; bus0.csr_rdata = 32'h0; bus0.csr_valid = 1'b1;
        @(negedge clk);
        bus0.req_valid = 2'b00;
        @(negedge clk);
        check("pre_rst_we", {31'd0, bus0.csr_we}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_we", {31'd0, bus0.csr_we}, 32'd0);
        check("mid_rst_addr", {20'd0, bus0.csr_addr}, 32'd0);
        check("mid_rst_wdata", bus0.csr_wdata, 32'd0);
        check("mid_rst_id", {31'd0, bus0.rsp_id}, 32'd0);
        check("mid_rst_rsp_valid", {31'd0, bus0.rsp_valid}, 32'd0);
        we_snap = we_cnt0;
        @(negedge clk);
        rst = 1'b0;
        rsp_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus0.rsp_valid === 1'b1) rsp_seen = rsp_seen + 1;
        end
        check("post_rst_rsp", rsp_seen, 32'd0);
        check("post_rst_we", we_cnt0 - we_snap, 32'd0);

        // Contention on both controllers: round-robin vs fixed priority.
        bus0.req_valid = 2'b11; bus0.req_addr = {12'h002, 12'h001}; bus0.req_op = 4'b0000;
        bus0.req_wdata = '0;
        bus1.req_valid = 2'b11; bus1.req_addr = {12'h002, 12'h001}; bus1.req_op = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rr_grant", {30'd0, bus0.req_ready}, {30'd0, exp_rr[i]});
            check("fix_grant", {30'd0, bus1.req_ready}, {30'd0, exp_fix[i]});
            repeat (3) @(negedge clk);
            check("rr_rsp_id", {31'd0, bus0.rsp_id}, {31'd0, exp_rr[i][1]});
            check("fix_rsp_id", {31'd0, bus1.rsp_id}, 32'd0);
            @(negedge clk);
        end
        bus0.req_valid = 2'b00;
        bus1.req_valid = 2'b00;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
